ioin_cfg_loader: RTL and testbench

//   Serial configuration loader for the IO input muxes: receives a framed bitstream and drives
//   the complementary select pairs (cbit/cbitb) and the prog gate for NUM_MUX 8:1 input muxes.

---
 rtl/ioin_cfg_loader_if.sv | 29 ++
 rtl/ioin_cfg_loader.sv | 137 +++++++++++++
 tb/tb_ioin_cfg_loader.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ioin_cfg_loader_if.sv
// ioin_cfg_loader_if
//   Bundles the serial config input and the mux select outputs of the
//   IO-input config loader.
//   master : drives cfg_start/sdi/sdi_valid, observes selects and status
//   slave  : the loader itself
//   Signals: cfg_start, sdi, sdi_valid (to loader); cbit, cbitb (4*NUM_MUX),
//            prog, cfg_done, cfg_err (from loader)
interface ioin_cfg_loader_if #(
  parameter int NUM_MUX = 2
);
  logic                   cfg_start;
  logic                   sdi;
  logic                   sdi_valid;
  logic [4*NUM_MUX-1:0]   cbit;
  logic [4*NUM_MUX-1:0]   cbitb;
  logic                   prog;
  logic                   cfg_done;
  logic                   cfg_err;

  modport master (
    output cfg_start, sdi, sdi_valid,
    input  cbit, cbitb, prog, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, sdi, sdi_valid,
    output cbit, cbitb, prog, cfg_done, cfg_err
  );
endinterface

// File: rtl/ioin_cfg_loader.sv
// ioin_cfg_loader
//   Serial configuration loader for the IO input muxes. Receives a frame of
//   SYNC header (8 bits, MSB first), 4*NUM_MUX data bits and one even-parity
//   bit, shadow-loads the data and commits all mux selects at once only when
//   header and parity are good. A failed frame leaves the live selects alone.
//   Ports:
//     clk  - config clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - ioin_cfg_loader_if slave: cfg_start/sdi/sdi_valid in;
//            cbit/cbitb selects, prog gate, cfg_done/cfg_err pulses out
module ioin_cfg_loader #(
  parameter int         NUM_MUX = 2,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  ioin_cfg_loader_if.slave    bus
);
  localparam int W  = 4 * NUM_MUX;
  localparam int CW = $clog2(4 * NUM_MUX + 9);

  typedef enum logic [2:0] {
    IDLE, HDR, DATA, PAR, COMMIT, ERROR
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      hdr_reg, hdr_next;
  logic [W-1:0]    shadow_reg, shadow_next;
  logic            par_reg, par_next;
  logic [W-1:0]    cbit_reg, cbit_next;
  logic            conf_reg, conf_next;
  logic            prog_reg, prog_next;
  logic            done_reg, done_next;
  logic            err_reg, err_next;
  logic [7:0]      hdr_shift;

  assign hdr_shift = {hdr_reg[6:0], bus.sdi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      hdr_reg    <= '0;
      shadow_reg <= '0;
      par_reg    <= 1'b0;
      cbit_reg   <= '0;
      conf_reg   <= 1'b0;
      prog_reg   <= 1'b1;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      hdr_reg    <= hdr_next;
      shadow_reg <= shadow_next;
      par_reg    <= par_next;
      cbit_reg   <= cbit_next;
      conf_reg   <= conf_next;
      prog_reg   <= prog_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hdr_next    = hdr_reg;
    shadow_next = shadow_reg;
    par_next    = par_reg;
    cbit_next   = cbit_reg;
    conf_next   = conf_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;

    // COMMIT/ERROR complete regardless of cfg_start; a start only redirects
    // the next state to HDR.
    if (state_reg == COMMIT) begin
      cbit_next  = shadow_reg;
      conf_next  = 1'b1;
      done_next  = 1'b1;
      state_next = IDLE;
    end
    if (state_reg == ERROR) begin
      err_next   = 1'b1;
      state_next = IDLE;
    end

    if (bus.cfg_start) begin
      // Abort/restart: any sdi bit presented this cycle is dropped.
      state_next  = HDR;
      cnt_next    = '0;
      hdr_next    = '0;
      shadow_next = '0;
      par_next    = 1'b0;
    end else if (bus.sdi_valid) begin
      case (state_reg)
        HDR: begin
          hdr_next = hdr_shift;
          if (cnt_reg == CW'(7)) begin
            cnt_next   = '0;
            state_next = (hdr_shift == SYNC) ? DATA : ERROR;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        DATA: begin
          // First data bit ends up in the MSB after W shifts.
          shadow_next = {shadow_reg[W-2:0], bus.sdi};
          par_next    = par_reg ^ bus.sdi;
          if (cnt_reg == CW'(W - 1)) begin
            cnt_next   = '0;
            state_next = PAR;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
        PAR: begin
          state_next = (par_reg ^ bus.sdi) ? ERROR : COMMIT;
        end
        default: ;
      endcase
    end

    // Gate stays closed through the COMMIT cycle so it opens on the same edge
    // that loads the new selects.
    prog_next = !conf_next || (state_next == HDR) || (state_next == DATA) ||
                (state_next == PAR) || (state_next == COMMIT);
  end

  assign bus.cbit     = cbit_reg;
  assign bus.cbitb    = ~cbit_reg;
  assign bus.prog     = prog_reg;
  assign bus.cfg_done = done_reg;
  assign bus.cfg_err  = err_reg;
endmodule

// File: tb/tb_ioin_cfg_loader.sv
module tb_ioin_cfg_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ioin_cfg_loader_if #(.NUM_MUX(2)) bus ();

  ioin_cfg_loader #(.NUM_MUX(2), .SYNC(8'hA5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         is_err;
    logic [7:0] cbit;
    bit         prog;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] cur_cfg = 8'h00;   // model of committed selects
  bit         configured = 0;
  bit         chk_prog_load = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  // Monitor: pops one expectation per cfg_done/cfg_err pulse.
  always @(negedge clk) begin
    if (!rst && (bus.cfg_done || bus.cfg_err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_event", {30'd0, bus.cfg_err, bus.cfg_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("event_kind_err", {31'd0, bus.cfg_err},  {31'd0, e.is_err});
        chk("event_kind_done", {31'd0, bus.cfg_done}, {31'd0, !e.is_err});
        chk("event_cbit", {24'd0, bus.cbit}, {24'd0, e.cbit});
        chk("event_cbitb", {24'd0, bus.cbitb}, {24'd0, ~e.cbit});
        chk("event_prog", {31'd0, bus.prog}, {31'd0, e.prog});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit with_valid);
    bus.cfg_start = 1'b1;
    bus.sdi       = 1'b1;
    bus.sdi_valid = with_valid;
    tick();
    bus.cfg_start = 1'b0;
    bus.sdi_valid = 1'b0;
  endtask

  task automatic send_bit(input bit b, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      bus.sdi_valid = 1'b0;
      tick();
      if (chk_prog_load) chk("prog_during_load_gap", {31'd0, bus.prog}, 32'd1);
    end
    bus.sdi       = b;
    bus.sdi_valid = 1'b1;
    tick();
    bus.sdi_valid = 1'b0;
    if (chk_prog_load) chk("prog_during_load", {31'd0, bus.prog}, 32'd1);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], gaps);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [7:0] data,
                            input bit par, input bit gaps);
    send_bits(hdr, 8, gaps);
    send_bits(data, 8, gaps);
    send_bit(par, gaps);
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 10) begin
      tick();
      k++;
    end
    tick();
    chk({name, "_drained"}, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  task automatic expect_event(input bit is_err, input logic [7:0] data);
    exp_t e;
    if (!is_err) begin
      cur_cfg    = data;
      configured = 1;
    end
    e.is_err = is_err;
    e.cbit   = cur_cfg;
    e.prog   = !configured;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cbit"},  {24'd0, bus.cbit},  32'h00);
    chk({tag, "_cbitb"}, {24'd0, bus.cbitb}, 32'hFF);
    chk({tag, "_prog"},  {31'd0, bus.prog},  32'd1);
    chk({tag, "_done"},  {31'd0, bus.cfg_done}, 32'd0);
    chk({tag, "_err"},   {31'd0, bus.cfg_err},  32'd0);
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.sdi       = 1'b0;
    bus.sdi_valid = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Bad parity before any commit: error, selects untouched, gate closed.
    do_start(0);
    expect_event(1, 8'h00);
    send_frame(8'hA5, 8'h3B, 1'b0, 0);
    drain("bad_parity");
    chk("bad_parity_cbit", {24'd0, bus.cbit}, 32'h00);
    chk("bad_parity_prog", {31'd0, bus.prog}, 32'd1);

    // Wrong header: error after 8th bit; trailing bits must not trigger anything.
    do_start(0);
    expect_event(1, 8'h00);
    send_bits(8'hA4, 8, 0);
    send_bits(8'h3B, 8, 0);
    send_bit(1'b1, 0);
    drain("bad_header");
    chk("bad_header_cbitb", {24'd0, bus.cbitb}, 32'hFF);

    // Good frame, gap-free.
    do_start(0);
    expect_event(0, 8'h3B);
    send_frame(8'hA5, 8'h3B, 1'b1, 0);
    drain("good_3b");
    chk("good_3b_prog_idle", {31'd0, bus.prog}, 32'd0);

    // Same frame with random sdi_valid gaps; prog must stay 1 while loading.
    do_start(0);
    chk("prog_after_start", {31'd0, bus.prog}, 32'd1);
    chk_prog_load = 1;
    expect_event(0, 8'h3B);
    send_frame(8'hA5, 8'h3B, 1'b1, 1);
    chk_prog_load = 0;
    drain("gaps_3b");

    // Reset mid-DATA after 5 data bits.
    do_start(0);
    send_bits(8'hA5, 8, 0);
    send_bits(8'h3B, 5, 0);
    rst = 1'b1;
    #1;
    check_reset_vals("midframe_rst");
    tick();
    rst = 1'b0;
    cur_cfg = 8'h00;
    configured = 0;
    tick();
    check_reset_vals("after_rst");

    // Recommit 3B, then abort mid-DATA and load 70; the restart carries a
    // valid sdi bit that must not be consumed.
    do_start(0);
    expect_event(0, 8'h3B);
    send_frame(8'hA5, 8'h3B, 1'b1, 0);
    drain("recommit_3b");
    do_start(0);
    send_bits(8'hA5, 8, 0);
    send_bits(8'h70, 3, 0);
    do_start(1);
    expect_event(0, 8'h70);
    send_frame(8'hA5, 8'h70, 1'b1, 0);
    drain("abort_70");
    repeat (3) tick();
    chk("final_cbit", {24'd0, bus.cbit}, 32'h70);
    chk("final_prog", {31'd0, bus.prog}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
